// File: rtl/demux_pkg.sv
// Shared types and helpers for the stream_demux_1ton block.
package demux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    DROP   = 2'd2
  } state_e;

  function automatic logic chk_sel(input int sel, input int n);
    return sel < n;
  endfunction

endpackage

// File: rtl/demux_hold_reg.sv
// One-deep holding register: a single beat plus its destination channel,
// with skid-free valid/ready so a load and a drain may share a cycle.
module demux_hold_reg #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic [SEL_W-1:0]  load_ch,
  input  logic              drain_ready,
  output logic              hold_valid,
  output logic [DATA_W-1:0] hold_data,
  output logic              hold_last,
  output logic [SEL_W-1:0]  hold_ch,
  output logic              hold_ready
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic [SEL_W-1:0]  ch_q, ch_d;

  assign hold_ready = !valid_q || drain_ready;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    ch_d    = ch_q;
    if (valid_q && drain_ready) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
      ch_d    = load_ch;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  // NOTE: the payload is deliberately not reset; it is only observable while valid_q is set.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    last_q <= last_d;
    ch_q   <= ch_d;
  end

  assign hold_valid = valid_q;
  assign hold_data  = data_q;
  assign hold_last  = last_q;
  assign hold_ch    = ch_q;

endmodule

// File: rtl/stream_demux_1ton.sv
// Registered 1-to-N packet-locked stream demultiplexer.
// Define DEMUX_CNT_EN to add saturating per-channel beat counters (beat_cnt).
module stream_demux_1ton
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_CH   = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic [SEL_W-1:0]       in_sel,
  output logic                   in_ready,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic [N_CH-1:0]        out_last,
  output logic [N_CH-1:0]        out_valid,
  input  logic [N_CH-1:0]        out_ready,
  output logic                   err_sel
`ifdef DEMUX_CNT_EN
  ,
  output logic [N_CH*CNT_W-1:0]  beat_cnt
`endif
);

  if (N_CH < 2 || N_CH > 16 || (2 ** SEL_W) < N_CH || CNT_W < 1) begin : g_param_check
    $error("stream_demux_1ton: illegal parameter combination");
  end

  state_e              state_q, state_d;
  logic                err_q, err_d;
  logic                load, accept;
  logic [SEL_W-1:0]    load_ch;
  logic                hold_valid, hold_last, hold_ready;
  logic [DATA_W-1:0]   hold_data;
  logic [SEL_W-1:0]    hold_ch;
  logic [2**SEL_W-1:0] ready_pad;

  // Widened so any hold_ch value indexes a defined bit.
  always_comb begin
    ready_pad            = '0;
    ready_pad[N_CH-1:0]  = out_ready;
  end

  assign in_ready = !rst && (state_q == DROP || hold_ready);
  assign accept   = in_valid && in_ready;

  demux_hold_reg #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_hold (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_data   (in_data),
    .load_last   (in_last),
    .load_ch     (load_ch),
    .drain_ready (ready_pad[hold_ch]),
    .hold_valid  (hold_valid),
    .hold_data   (hold_data),
    .hold_last   (hold_last),
    .hold_ch     (hold_ch),
    .hold_ready  (hold_ready)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    load    = 1'b0;
    load_ch = hold_ch;
    unique case (state_q)
      IDLE: if (accept) begin
        if (chk_sel(int'(in_sel), N_CH)) begin
          load    = 1'b1;
          load_ch = in_sel;
          if (!in_last) state_d = LOCKED;
        end else begin
          err_d = 1'b1;
          if (!in_last) state_d = DROP;
        end
      end
      LOCKED: if (accept) begin
        load = 1'b1;
        if (in_last) state_d = IDLE;
      end
      DROP: if (accept && in_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign err_sel = err_q;

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    out_last  = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (hold_valid && hold_ch == SEL_W'(k)) begin
        out_valid[k]                 = 1'b1;
        out_data[k*DATA_W +: DATA_W] = hold_data;
        out_last[k]                  = hold_last;
      end
    end
  end

`ifdef DEMUX_CNT_EN
  logic [N_CH*CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < N_CH; k++) begin
      if (out_valid[k] && out_ready[k] && cnt_q[k*CNT_W +: CNT_W] != {CNT_W{1'b1}})
        cnt_d[k*CNT_W +: CNT_W] = cnt_q[k*CNT_W +: CNT_W] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign beat_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Directed bench for stream_demux_1ton: a 4-channel instance (a_*) and a
// 3-channel instance with 2-bit counters (b_*) for the out-of-range select.
module tb_stream_demux_1ton;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  a_data, b_data;
  logic        a_valid, a_last, b_valid, b_last;
  logic [1:0]  a_sel, b_sel;
  logic        a_ready, b_ready;
  logic [31:0] a_odata;
  logic [23:0] b_odata;
  logic [3:0]  a_olast, a_ovalid, a_oready;
  logic [2:0]  b_olast, b_ovalid, b_oready;
  logic        a_err, b_err;
`ifdef DEMUX_CNT_EN
  logic [63:0] a_cnt;
  logic [5:0]  b_cnt;
`endif

  stream_demux_1ton dut_a (
    .clk(clk), .rst(rst),
    .in_data(a_data), .in_valid(a_valid), .in_last(a_last), .in_sel(a_sel),
    .in_ready(a_ready), .out_data(a_odata), .out_last(a_olast),
    .out_valid(a_ovalid), .out_ready(a_oready), .err_sel(a_err)
`ifdef DEMUX_CNT_EN
    , .beat_cnt(a_cnt)
`endif
  );

  stream_demux_1ton #(.DATA_W(8), .N_CH(3), .SEL_W(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .in_data(b_data), .in_valid(b_valid), .in_last(b_last), .in_sel(b_sel),
    .in_ready(b_ready), .out_data(b_odata), .out_last(b_olast),
    .out_valid(b_ovalid), .out_ready(b_oready), .err_sel(b_err)
`ifdef DEMUX_CNT_EN
    , .beat_cnt(b_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [7:0]  data;
    logic [3:0]  exp_valid;
    logic [31:0] exp_data;
  } route_vec_t;

  route_vec_t vecs[4];

  initial begin
    vecs[0] = '{sel: 2'd2, data: 8'hA5, exp_valid: 4'b0100, exp_data: 32'h00A5_0000};
    vecs[1] = '{sel: 2'd0, data: 8'h3C, exp_valid: 4'b0001, exp_data: 32'h0000_003C};
    vecs[2] = '{sel: 2'd1, data: 8'hC3, exp_valid: 4'b0010, exp_data: 32'h0000_C300};
    vecs[3] = '{sel: 2'd3, data: 8'h7E, exp_valid: 4'b1000, exp_data: 32'h7E00_0000};

    rst = 1'b1;
    a_data = 8'h00; a_valid = 1'b1; a_last = 1'b1; a_sel = 2'd0; a_oready = 4'hF;
    b_data = 8'h00; b_valid = 1'b1; b_last = 1'b1; b_sel = 2'd0; b_oready = 3'b111;

    // Reset held for three cycles with traffic offered.
    repeat (3) tick();
    check("rst_a_ready", a_ready, 1'b0);
    check("rst_b_ready", b_ready, 1'b0);
    check("rst_a_ovalid", a_ovalid, 4'b0000);
    check("rst_a_odata", a_odata, 32'h0);
    check("rst_a_olast", a_olast, 4'b0000);
    check("rst_a_err", a_err, 1'b0);
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    tick();
    check("post_rst_a_ready", a_ready, 1'b1);
    check("post_rst_a_ovalid", a_ovalid, 4'b0000);

    // Single-beat routing, back to back.
    for (int i = 0; i < 4; i++) begin
      a_valid = 1'b1; a_last = 1'b1; a_sel = vecs[i].sel; a_data = vecs[i].data;
      tick();
      a_valid = 1'b0;
      check($sformatf("route%0d_valid", i), a_ovalid, vecs[i].exp_valid);
      check($sformatf("route%0d_data", i), a_odata, vecs[i].exp_data);
      check($sformatf("route%0d_last", i), a_olast, vecs[i].exp_valid);
    end
    tick();
    check("route_drained", a_ovalid, 4'b0000);

    // Packet lock: select changes mid-packet are ignored.
    a_valid = 1'b1; a_last = 1'b0; a_sel = 2'd1; a_data = 8'h11;
    tick();
    check("lock_b1_valid", a_ovalid, 4'b0010);
    check("lock_b1_data", a_odata, 32'h0000_1100);
    check("lock_b1_last", a_olast, 4'b0000);
    a_sel = 2'd3; a_data = 8'h22;
    tick();
    check("lock_b2_valid", a_ovalid, 4'b0010);
    check("lock_b2_data", a_odata, 32'h0000_2200);
    a_last = 1'b1; a_data = 8'h33;
    tick();
    check("lock_b3_valid", a_ovalid, 4'b0010);
    check("lock_b3_data", a_odata, 32'h0000_3300);
    check("lock_b3_last", a_olast, 4'b0010);
    a_data = 8'h44;
    tick();
    check("lock_next_valid", a_ovalid, 4'b1000);
    check("lock_next_data", a_odata, 32'h4400_0000);
    a_valid = 1'b0;
    tick();
    check("lock_drained", a_ovalid, 4'b0000);

    // Backpressure on channel 0, then 1 beat/cycle streaming.
    a_oready = 4'b1110;
    a_valid = 1'b1; a_last = 1'b1; a_sel = 2'd0; a_data = 8'h5A;
    tick();
    a_data = 8'h60;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("bp%0d_ready", i), a_ready, 1'b0);
      check($sformatf("bp%0d_data", i), a_odata, 32'h0000_005A);
      check($sformatf("bp%0d_valid", i), a_ovalid, 4'b0001);
    end
    a_oready = 4'hF;
    #1;
    check("bp_release_ready", a_ready, 1'b1);
    tick();
    check("bp_release_data", a_odata, 32'h0000_0060);
    for (int i = 1; i <= 8; i++) begin
      a_data = 8'h60 + 8'(i);
      check($sformatf("stream%0d_ready", i), a_ready, 1'b1);
      tick();
      check($sformatf("stream%0d_data", i), a_odata, 32'(8'h60 + 8'(i)));
      check($sformatf("stream%0d_valid", i), a_ovalid, 4'b0001);
    end
    a_valid = 1'b0;
    tick();
    check("stream_drained", a_ovalid, 4'b0000);

    // Reset during beat 2 of a 4-beat packet to channel 2.
    a_valid = 1'b1; a_last = 1'b0; a_sel = 2'd2; a_data = 8'h91;
    tick();
    check("midrst_b1_valid", a_ovalid, 4'b0100);
    rst = 1'b1; a_data = 8'h92;
    tick();
    check("midrst_ovalid", a_ovalid, 4'b0000);
    check("midrst_odata", a_odata, 32'h0);
    check("midrst_ready", a_ready, 1'b0);
    rst = 1'b0; a_valid = 1'b0;
    tick();
    check("midrst_quiet", a_ovalid, 4'b0000);
    // A fresh packet must take its own select, proving the lock is gone.
    a_valid = 1'b1; a_last = 1'b1; a_sel = 2'd1; a_data = 8'hB1;
    tick();
    check("midrst_new_valid", a_ovalid, 4'b0010);
    check("midrst_new_data", a_odata, 32'h0000_B100);
    a_valid = 1'b0;
    tick();
    check("midrst_new_drained", a_ovalid, 4'b0000);

    // Five single-beat packets to channel 0.
    for (int i = 0; i < 5; i++) begin
      a_valid = 1'b1; a_last = 1'b1; a_sel = 2'd0; a_data = 8'(i);
      tick();
    end
    a_valid = 1'b0;
    tick();
    check("cnt_tail_data_gone", a_ovalid, 4'b0000);
`ifdef DEMUX_CNT_EN
    check("cnt_a", a_cnt, 64'h0000_0000_0001_0005);
`endif

    // Out-of-range select on the 3-channel instance.
    check("bad_err_clear", b_err, 1'b0);
    b_valid = 1'b1; b_last = 1'b0; b_sel = 2'd3; b_data = 8'hEE;
    check("bad_b1_ready", b_ready, 1'b1);
    tick();
    check("bad_b1_ovalid", b_ovalid, 3'b000);
    check("bad_b1_err", b_err, 1'b1);
    b_last = 1'b1; b_sel = 2'd0; b_data = 8'hEF;
    check("bad_b2_ready", b_ready, 1'b1);
    tick();
    check("bad_b2_ovalid", b_ovalid, 3'b000);
    check("bad_b2_err", b_err, 1'b1);
    b_sel = 2'd2; b_data = 8'h12;
    tick();
    check("bad_next_valid", b_ovalid, 3'b100);
    check("bad_next_data", b_odata, 24'h12_0000);
    check("bad_err_sticky", b_err, 1'b1);

    // Six beats to channel 0 of the 2-bit-counter instance.
    for (int i = 0; i < 6; i++) begin
      b_sel = 2'd0; b_data = 8'h80 + 8'(i);
      tick();
      check($sformatf("sat%0d_data", i), b_odata, 24'(8'h80 + 8'(i)));
    end
    b_valid = 1'b0;
    tick();
    check("sat_drained", b_ovalid, 3'b000);
    check("sat_err_still", b_err, 1'b1);
`ifdef DEMUX_CNT_EN
    check("cnt_b_sat", b_cnt, 6'b01_00_11);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
